i2s_adc_rx: RTL and testbench
=============================

I2S_ADC_RX -- requirements
Module: i2s_adc_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: bits captured per channel slot, 16 to 32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on each I2S input, 2 to 3.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i2s_bclk, input, 1 bit: bit clock from the codec-side clock generator; asynchronous to clk, at most clk/8.
REQ-006 SHALL have port i2s_lrclk, input, 1 bit: word select; low means left, high means right.
REQ-007 SHALL have port i2s_adcdat, input, 1 bit: serial ADC data, MSB first.
REQ-008 SHALL have port sample_left, output, DATA_WIDTH bits: captured left word.
REQ-009 SHALL have port sample_right, output, DATA_WIDTH bits: captured right word.
REQ-010 SHALL have port sample_valid, output, 1 bit: the stereo pair on sample_left/sample_right is available.
REQ-011 SHALL have port sample_ready, input, 1 bit: the consumer accepts the pair.
REQ-012 SHALL have port overrun, output, 1 bit: sticky; a pair was dropped.
REQ-013 SHALL have port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-014 SHALL pass each I2S input through SYNC_STAGES flops before use, and SHALL use no logic clocked by i2s_bclk.
REQ-015 SHALL detect a bclk rising edge as synced bclk 1 with the previous synced value 0; all sampling happens only in clk cycles where this edge is detected.
REQ-016 SHALL, on each bclk edge, sample synced lrclk and adcdat, and SHALL hold lrclk_prev, the lrclk value from the previous bclk edge.
REQ-017 SHALL treat lrclk != lrclk_prev as a slot boundary; per I2S timing, the MSB arrives on the next bclk edge after the boundary, not on the boundary edge itself.
REQ-018 SHALL implement the state machine SYNC -> LEFT -> RIGHT -> LEFT ... :
- SYNC: entered at reset; ignores data until a 1->0 lrclk boundary, then goes to LEFT.
- LEFT: goes to RIGHT on a 0->1 boundary.
- RIGHT: goes to LEFT on a 1->0 boundary.
REQ-019 SHALL, in LEFT/RIGHT, shift the first DATA_WIDTH bits after the boundary into the channel shift register MSB first, and SHALL ignore further bits in that slot.
REQ-020 SHALL, when a slot ends with fewer than DATA_WIDTH bits, left-align the captured bits and zero-fill the LSBs.
REQ-021 SHALL latch the left word at the 0->1 boundary that ends the left slot.
REQ-022 SHALL form the stereo pair at the 1->0 boundary that ends the right slot, and SHALL assert sample_valid in the clk cycle after that boundary edge.
REQ-023 SHALL hold sample_left, sample_right and sample_valid stable until a cycle in which sample_valid and sample_ready are both 1; sample_valid drops in the next cycle unless a new pair is completed in that same cycle.
REQ-024 SHALL, if a pair completes while sample_valid=1 and sample_ready=0, discard the new pair, keep the old pair, and set overrun.
REQ-025 SHALL, if a pair completes in the same cycle as a handshake, load the new pair and keep sample_valid=1, with no overrun.
REQ-026 SHALL, if overrun_clr and a new overrun occur in the same cycle, leave overrun=1 (set wins).
REQ-027 SHALL reset the bit counter at every boundary; the counter saturates at DATA_WIDTH and does not wrap.

Reset
REQ-028 SHALL, when rst=1, force: state SYNC, sample_left=0, sample_right=0, sample_valid=0, overrun=0, shift registers/counters/lrclk_prev=0, synchronizer flops=0.
REQ-029 SHALL, when rst is asserted mid-slot, discard any partial word and make no further output until after the next full SYNC.

Structure
REQ-030 SHALL place the state enum (SYNC/LEFT/RIGHT) and the DATA_WIDTH default constant in shared package i2s_pkg.
REQ-031 SHALL use one sub-module, i2s_in_sync: a SYNC_STAGES-deep synchronizer that also produces the bclk rising-edge strobe.
REQ-032 SHALL keep the channel datapath (shift, align, latch) in i2s_adc_rx itself.

Verification (clk 100 MHz, bclk = clk/8, 32-bit slots, DATA_WIDTH=24)
REQ-033 SHALL check basic capture: frames L=0x123456, R=0xABCDEF with sample_ready=1 -> sample_left=0x123456, sample_right=0xABCDEF, sample_valid high for one cycle per frame.
REQ-034 SHALL check startup sync: release reset in mid-right slot -> no sample_valid until a full left+right frame; first pair exactly matches the driven frame.
REQ-035 SHALL check backpressure: sample_ready=0 over two frames (0x000001/0x000002, then 0x000003/0x000004) -> the first pair is held, overrun=1; after sample_ready=1 the pair reads 0x000001/0x000002; overrun_clr -> overrun=0.
REQ-036 SHALL check short slots: 16-bit slots with L=0xBEEF, R=0x1234 -> sample_left=0xBEEF00, sample_right=0x123400.
REQ-037 SHALL check reset mid-operation: rst pulsed during the 10th bit of a left word -> all outputs 0 the next cycle; the next valid pair comes from a complete later frame.
REQ-038 SHALL check simultaneous events: a handshake in the pair-completion cycle -> new pair loaded, sample_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and default constants for the I2S ADC receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Bits captured per channel slot unless overridden at instantiation.
    localparam int DATA_WIDTH_DEFAULT  = 24;

    // Synchronizer depth on each I2S input unless overridden.
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Frame tracking state: SYNC waits for the first left slot, then the
    // receiver alternates LEFT/RIGHT on every word-select boundary.
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_t;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_in_sync
//  Description : Multi-flop synchronizer for the three I2S inputs plus a
//                bit-clock rising-edge strobe in the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic bclk,
    input  logic lrclk,
    input  logic adcdat,
    output logic bclk_rise,
    output logic lrclk_sync,
    output logic adcdat_sync
);

    // All three inputs travel through the same depth so that word select and
    // data stay aligned with the bit-clock edge that samples them.
    logic [SYNC_STAGES-1:0] r_bclk_ff;
    logic [SYNC_STAGES-1:0] r_lrclk_ff;
    logic [SYNC_STAGES-1:0] r_adcdat_ff;
    logic                   r_bclk_prev;

    // Shift each asynchronous input through its synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_ff   <= '0;
            r_lrclk_ff  <= '0;
            r_adcdat_ff <= '0;
        end else begin
            r_bclk_ff   <= {r_bclk_ff[SYNC_STAGES-2:0],   bclk};
            r_lrclk_ff  <= {r_lrclk_ff[SYNC_STAGES-2:0],  lrclk};
            r_adcdat_ff <= {r_adcdat_ff[SYNC_STAGES-2:0], adcdat};
        end
    end

    // Remember the previous synchronized bit clock for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_prev <= 1'b0;
        end else begin
            r_bclk_prev <= r_bclk_ff[SYNC_STAGES-1];
        end
    end

    assign bclk_rise   = r_bclk_ff[SYNC_STAGES-1] & ~r_bclk_prev;
    assign lrclk_sync  = r_lrclk_ff[SYNC_STAGES-1];
    assign adcdat_sync = r_adcdat_ff[SYNC_STAGES-1];

endmodule : i2s_in_sync
`default_nettype wire

// File: rtl/i2s_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_adc_rx
//  Description : I2S ADC receiver. Oversamples bclk/lrclk/adcdat in the clk
//                domain, captures left/right words MSB first and presents
//                them as a stereo pair with a valid/ready handshake and a
//                sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_adc_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_adcdat,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    // ------------------------------------------------------------------
    // Synchronized inputs
    // ------------------------------------------------------------------
    logic w_bclk_rise;
    logic w_lrclk_sync;
    logic w_adcdat_sync;

    i2s_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk         (clk),
        .rst         (rst),
        .bclk        (i2s_bclk),
        .lrclk       (i2s_lrclk),
        .adcdat      (i2s_adcdat),
        .bclk_rise   (w_bclk_rise),
        .lrclk_sync  (w_lrclk_sync),
        .adcdat_sync (w_adcdat_sync)
    );

    // ------------------------------------------------------------------
    // Slot boundary detection
    // ------------------------------------------------------------------
    logic r_lrclk_prev;
    logic w_boundary;
    logic w_data_edge;

    assign w_boundary  = w_bclk_rise && (w_lrclk_sync != r_lrclk_prev);
    assign w_data_edge = w_bclk_rise && (w_lrclk_sync == r_lrclk_prev);

    // Track word select as seen on the previous bit-clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lrclk_prev <= 1'b0;
        end else if (w_bclk_rise) begin
            r_lrclk_prev <= w_lrclk_sync;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    rx_state_t r_state;
    rx_state_t w_state_next;
    logic      w_capture_en;
    logic      w_end_left;
    logic      w_end_right;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Advance only on word-select boundaries of the expected direction.
    always_comb begin
        w_state_next = r_state;
        if (w_boundary) begin
            case (r_state)
                ST_SYNC:  if (!w_lrclk_sync) w_state_next = ST_LEFT;
                ST_LEFT:  if (w_lrclk_sync)  w_state_next = ST_RIGHT;
                ST_RIGHT: if (!w_lrclk_sync) w_state_next = ST_LEFT;
                default:                     w_state_next = ST_SYNC;
            endcase
        end
    end

    // Decode capture enable and the slot-ending events from the state.
    always_comb begin
        w_capture_en = 1'b0;
        w_end_left   = 1'b0;
        w_end_right  = 1'b0;
        case (r_state)
            ST_LEFT: begin
                w_capture_en = 1'b1;
                w_end_left   = w_boundary && w_lrclk_sync;
            end
            ST_RIGHT: begin
                w_capture_en = 1'b1;
                w_end_right  = w_boundary && !w_lrclk_sync;
            end
            default: begin
                w_capture_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Channel datapath
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  w_has_room;
    logic [DATA_WIDTH-1:0] w_final_shift;
    logic [CNT_W-1:0]      w_final_cnt;
    logic [DATA_WIDTH-1:0] w_aligned;

    assign w_has_room = (r_bit_cnt < FULL_CNT);

    // The bit sampled on a boundary edge is the LSB of the slot that is
    // ending, so it joins that word before left-alignment.
    always_comb begin
        w_final_shift = r_shift;
        w_final_cnt   = r_bit_cnt;
        if (w_has_room) begin
            w_final_shift = {r_shift[DATA_WIDTH-2:0], w_adcdat_sync};
            w_final_cnt   = r_bit_cnt + CNT_W'(1);
        end
        w_aligned = w_final_shift << (FULL_CNT - w_final_cnt);
    end

    // Shift in data bits MSB first; the counter saturates at DATA_WIDTH and
    // both are cleared at every slot boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_boundary) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_data_edge && w_capture_en && w_has_room) begin
            r_shift   <= {r_shift[DATA_WIDTH-2:0], w_adcdat_sync};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    // Hold the completed left word until its right partner arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_hold <= '0;
        end else if (w_end_left) begin
            r_left_hold <= w_aligned;
        end
    end

    // ------------------------------------------------------------------
    // Output handshake and overrun
    // ------------------------------------------------------------------
    logic w_accept_pair;
    logic w_overrun_set;

    assign w_accept_pair = w_end_right && (!sample_valid || sample_ready);
    assign w_overrun_set = w_end_right && sample_valid && !sample_ready;

    // Load a new pair when the output slot is free or being consumed now.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
        end else if (w_accept_pair) begin
            sample_left  <= r_left_hold;
            sample_right <= w_aligned;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (w_overrun_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule : i2s_adc_rx
`default_nettype wire

// File: tb/tb_i2s_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_adc_rx
//  Description : Self-checking bench for i2s_adc_rx with a pair scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_adc_rx;

    localparam int DW = 24;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          i2s_bclk     = 1'b0;
    logic          i2s_lrclk    = 1'b1;
    logic          i2s_adcdat   = 1'b0;
    logic          sample_ready = 1'b1;
    logic          overrun_clr  = 1'b0;
    logic [DW-1:0] sample_left;
    logic [DW-1:0] sample_right;
    logic          sample_valid;
    logic          overrun;

    int               checks       = 0;
    int               errors       = 0;
    int               valid_cycles = 0;
    logic             last_lsb     = 1'b0;
    logic [2*DW-1:0]  sb[$];

    always #5 clk = ~clk;

    i2s_adc_rx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_adcdat   (i2s_adcdat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake consumes the oldest expected pair.
    always @(negedge clk) begin
        if (sample_valid) valid_cycles++;
        if (sample_valid && sample_ready && !rst) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [2*DW-1:0] exp_pair;
                exp_pair = sb.pop_front();
                check("pair_left",  64'(sample_left),  64'(exp_pair[2*DW-1:DW]));
                check("pair_right", 64'(sample_right), 64'(exp_pair[DW-1:0]));
            end
        end
    end

    // One bclk period: data/word select change while bclk is low.
    task automatic send_bit(input logic lr, input logic d, input bit do_rst);
        @(negedge clk);
        i2s_bclk   = 1'b0;
        i2s_lrclk  = lr;
        i2s_adcdat = d;
        repeat (4) @(negedge clk);
        i2s_bclk = 1'b1;
        if (do_rst) begin
            check("pre_rst_valid", 64'(sample_valid), 64'd1);
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1;
            check("rst_left",    64'(sample_left),  64'd0);
            check("rst_right",   64'(sample_right), 64'd0);
            check("rst_valid",   64'(sample_valid), 64'd0);
            check("rst_overrun", 64'(overrun),      64'd0);
            rst = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    // Standard I2S frame; words are left-aligned in 32 bits, slot <= 32.
    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                              input int slot, input int rst_bit);
        for (int k = 0; k < slot; k++)
            send_bit(1'b0, (k == 0) ? last_lsb : lw[32-k], (k == rst_bit));
        last_lsb = lw[32-slot];
        for (int k = 0; k < slot; k++)
            send_bit(1'b1, (k == 0) ? last_lsb : rw[32-k], 1'b0);
        last_lsb = rw[32-slot];
    endtask

    task automatic frame24(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit push);
        if (push) sb.push_back({l, r});
        send_frame({l, 8'h00}, {r, 8'h00}, 32, -1);
    endtask

    // First edge of a following left slot completes the pending pair.
    task automatic tail();
        send_bit(1'b0, last_lsb, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic preamble(input int n);
        for (int k = 0; k < n; k++) send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_lsb = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] ra, rb;

        // ---- reset state ----
        repeat (4) @(posedge clk);
        #1;
        check("reset_left",    64'(sample_left),  64'd0);
        check("reset_right",   64'(sample_right), 64'd0);
        check("reset_valid",   64'(sample_valid), 64'd0);
        check("reset_overrun", 64'(overrun),      64'd0);
        rst = 1'b0;

        // ---- basic capture, back-to-back frames, ready held high ----
        valid_cycles = 0;
        preamble(4);
        ra = DW'($urandom);
        rb = DW'($urandom);
        frame24(24'h123456, 24'hABCDEF, 1'b1);
        frame24(24'hFFFFFF, 24'h800001, 1'b1);
        frame24(ra, rb, 1'b1);
        tail();
        check("basic_valid_cycles", 64'(valid_cycles), 64'd3);
        check("basic_sb_drained",   64'(sb.size()),    64'd0);
        check("basic_overrun",      64'(overrun),      64'd0);

        // ---- startup sync: reset released in mid-right slot ----
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 32; k++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 16; k++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        rst = 1'b0;
        valid_cycles = 0;
        for (int k = 0; k < 16; k++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("sync_no_early_valid", 64'(valid_cycles), 64'd0);
        frame24(24'h5A5A5A, 24'hC3C3C3, 1'b1);
        tail();
        check("sync_valid_cycles", 64'(valid_cycles), 64'd1);

        // ---- backpressure and overrun ----
        do_reset();
        sample_ready = 1'b0;
        preamble(4);
        frame24(24'h000001, 24'h000002, 1'b1);
        frame24(24'h000003, 24'h000004, 1'b0);
        tail();
        check("bp_valid",   64'(sample_valid), 64'd1);
        check("bp_left",    64'(sample_left),  64'h000001);
        check("bp_right",   64'(sample_right), 64'h000002);
        check("bp_overrun", 64'(overrun),      64'd1);
        @(posedge clk); #1 sample_ready = 1'b1;
        @(posedge clk); #1 sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_valid_drop",      64'(sample_valid), 64'd0);
        check("bp_overrun_sticky",  64'(overrun),      64'd1);
        overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        check("bp_overrun_cleared", 64'(overrun),      64'd0);
        sample_ready = 1'b1;

        // ---- short 16-bit slots, left-aligned and zero-filled ----
        do_reset();
        preamble(4);
        sb.push_back({24'hBEEF00, 24'h123400});
        send_frame({16'hBEEF, 16'h0000}, {16'h1234, 16'h0000}, 16, -1);
        sb.push_back({24'hFFFF00, 24'h800100});
        send_frame({16'hFFFF, 16'h0000}, {16'h8001, 16'h0000}, 16, -1);
        tail();
        check("short_sb_drained", 64'(sb.size()), 64'd0);

        // ---- reset during the 10th bit of a left word ----
        do_reset();
        sample_ready = 1'b0;
        preamble(4);
        frame24(24'h0A0B0C, 24'h0D0E0F, 1'b0);
        send_frame({24'h777777, 8'h00}, {24'h888888, 8'h00}, 32, 10);
        sample_ready = 1'b1;
        valid_cycles = 0;
        frame24(24'h13579B, 24'h2468AC, 1'b1);
        tail();
        check("midrst_valid_cycles", 64'(valid_cycles), 64'd1);

        // ---- handshake in the same cycle a new pair completes ----
        do_reset();
        sample_ready = 1'b0;
        preamble(4);
        frame24(24'h111111, 24'h222222, 1'b1);
        frame24(24'h333333, 24'h444444, 1'b1);
        @(negedge clk);
        i2s_bclk   = 1'b0;
        i2s_lrclk  = 1'b0;
        i2s_adcdat = last_lsb;
        repeat (4) @(negedge clk);
        i2s_bclk = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 sample_ready = 1'b1;
        @(posedge clk); #1 sample_ready = 1'b0;
        check("simul_valid",   64'(sample_valid), 64'd1);
        check("simul_left",    64'(sample_left),  64'h333333);
        check("simul_right",   64'(sample_right), 64'h444444);
        check("simul_overrun", 64'(overrun),      64'd0);
        repeat (3) @(posedge clk);
        #1 sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_sb_drained", 64'(sb.size()),    64'd0);
        check("final_valid",      64'(sample_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_i2s_adc_rx
`default_nettype wire
